// File: rtl/down_counter_timer_pkg.sv
// Shared constants for the loadable down-counter timer: state encoding and default width.
package down_counter_timer_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    typedef enum logic {
        StIdle = ST_IDLE,
        StRun  = ST_RUN
    } state_e;

endpackage

// File: rtl/down_counter_timer_step.sv
// Toggle-flip-flop borrow chain: decrements by one when enabled, with a synchronous
// parallel load that takes priority over the decrement.
module down_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] toggle;

    // Bit i toggles only when every lower bit is 0 (borrow ripples upward).
    always_comb begin
        toggle[0] = enable;
        for (int i = 1; i < int'(WIDTH); i++) begin
            toggle[i] = toggle[i-1] & ~count_q[i-1];
        end
    end

    always_comb begin
        count_d = count_q ^ toggle;
        if (load) begin
            count_d = load_value;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counter with a registered terminal-count pulse, usable as a
// one-shot timer or an auto-reloading rate divider.
module down_counter_timer
    import down_counter_timer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             periodic,
    output logic [WIDTH-1:0] Q,
    output logic             done,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] reload_q;
    logic             done_q, done_d;
    logic             terminal;
    logic             running;
    logic             step_en;
    logic             step_load;
    logic [WIDTH-1:0] step_value;

    assign running  = (state_q == StRun) && !load && enable;
    assign terminal = (Q == WIDTH'(1));

    // Periodic reload goes through the parallel-load port; one-shot terminal just
    // decrements 1 -> 0.
    assign step_load  = load || (running && terminal && periodic);
    assign step_value = load ? load_value : reload_q;
    assign step_en    = running && !(terminal && periodic);

    down_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (step_en),
        .load       (step_load),
        .load_value (step_value),
        .count      (Q)
    );

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        if (load) begin
            state_d = (load_value != '0) ? StRun : StIdle;
        end else if (running && terminal) begin
            done_d = 1'b1;
            if (!periodic) begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (load) begin
                reload_q <= load_value;
            end
        end
    end

    assign done = done_q;
    assign busy = (state_q == StRun);

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed self-checking bench for down_counter_timer (WIDTH=8).
module tb_down_counter_timer;

    logic       clock;
    logic       reset_n;
    logic       load;
    logic [7:0] load_value;
    logic       enable;
    logic       periodic;
    logic [7:0] Q;
    logic       done;
    logic       busy;

    int total = 0;
    int bad   = 0;

    down_counter_timer #(
        .WIDTH (8)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (load),
        .load_value (load_value),
        .enable     (enable),
        .periodic   (periodic),
        .Q          (Q),
        .done       (done),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all(input string name, input logic [7:0] eq, input logic ed,
                             input logic eb);
        total++;
        if (Q !== eq) begin
            bad++;
            $display("FAIL %s Q: got %0d expected %0d", name, Q, eq);
        end
        total++;
        if (done !== ed) begin
            bad++;
            $display("FAIL %s done: got %b expected %b", name, done, ed);
        end
        total++;
        if (busy !== eb) begin
            bad++;
            $display("FAIL %s busy: got %b expected %b", name, busy, eb);
        end
    endtask

    task automatic do_load(input logic [7:0] v);
        load       = 1'b1;
        load_value = v;
        tick();
        load       = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        check_all("reset_async", 8'd0, 1'b0, 1'b0);
        tick();
        reset_n = 1'b1;
        enable  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_all("reset_idle", 8'd0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_oneshot();
        logic [7:0] exp_q [5] = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
        periodic = 1'b0;
        enable   = 1'b1;
        do_load(8'd5);
        check_all("oneshot_load", 8'd5, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_all("oneshot_count", exp_q[i], (i == 4), (i != 4));
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            check_all("oneshot_hold", 8'd0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_periodic();
        logic [7:0] exp_q [12] = '{8'd2, 8'd1, 8'd3, 8'd2, 8'd1, 8'd3,
                                   8'd2, 8'd1, 8'd3, 8'd2, 8'd1, 8'd3};
        int pulses = 0;
        periodic = 1'b1;
        enable   = 1'b1;
        do_load(8'd3);
        check_all("periodic_load", 8'd3, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            tick();
            check_all("periodic_count", exp_q[i], (i % 3 == 2), 1'b1);
            if (done === 1'b1) pulses++;
        end
        total++;
        if (pulses !== 4) begin
            bad++;
            $display("FAIL periodic_pulses: got %0d expected 4", pulses);
        end
    endtask

    task automatic test_enable_gating();
        logic       en_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [7:0] exp_q  [6] = '{8'd3, 8'd3, 8'd3, 8'd2, 8'd1, 8'd0};
        periodic = 1'b0;
        enable   = 1'b0;
        do_load(8'd4);
        check_all("gate_load", 8'd4, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            enable = en_pat[i];
            tick();
            check_all("gate_count", exp_q[i], (i == 5), (i != 5));
        end
        tick();
        check_all("gate_after", 8'd0, 1'b0, 1'b0);
    endtask

    task automatic test_load_collision();
        periodic = 1'b1;
        enable   = 1'b1;
        do_load(8'd2);
        tick();
        check_all("coll_at_one", 8'd1, 1'b0, 1'b1);
        do_load(8'd9);
        check_all("coll_load9", 8'd9, 1'b0, 1'b1);
        do_load(8'd0);
        check_all("coll_load0", 8'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("coll_idle", 8'd0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reload_one();
        periodic = 1'b1;
        enable   = 1'b1;
        do_load(8'd1);
        check_all("r1_load", 8'd1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("r1_every_cycle", 8'd1, 1'b1, 1'b1);
        end
        enable = 1'b0;
        tick();
        check_all("r1_gated", 8'd1, 1'b0, 1'b1);
    endtask

    task automatic test_async_reset();
        periodic = 1'b0;
        enable   = 1'b1;
        do_load(8'd200);
        check_all("ar_load", 8'd200, 1'b0, 1'b1);
        for (int i = 0; i < 50; i++) tick();
        check_all("ar_150", 8'd150, 1'b0, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check_all("ar_immediate", 8'd0, 1'b0, 1'b0);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_all("ar_after", 8'd0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        load       = 1'b0;
        load_value = 8'd0;
        enable     = 1'b0;
        periodic   = 1'b0;
        test_reset();
        test_oneshot();
        test_periodic();
        test_enable_gating();
        test_load_collision();
        test_reload_one();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
